// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-register taps and hazard-unit results for fwd_hazard_unit.
// master: pipeline side (drives taps); slave: the hazard unit.
// Stats ports exist only when FWD_HAZARD_STATS_EN is defined.
interface fwd_hazard_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5
);
  logic [NUM_SRC*REG_AW-1:0] ifid_rs;
  logic [NUM_SRC-1:0]        ifid_rs_used;
  logic                      ifid_mc;
  logic [REG_AW-1:0]         ifid_rd;
  logic [NUM_SRC*REG_AW-1:0] idex_rs;
  logic [REG_AW-1:0]         idex_rd;
  logic                      idex_regwrite;
  logic                      idex_memread;
  logic [REG_AW-1:0]         exmem_rd;
  logic                      exmem_regwrite;
  logic [REG_AW-1:0]         memwb_rd;
  logic                      memwb_regwrite;
  logic                      ex_flush;
  logic [2*NUM_SRC-1:0]      forward_sel;
  logic                      stall;
  logic                      mc_busy;
  logic [REG_AW-1:0]         mc_rd;
`ifdef FWD_HAZARD_STATS_EN
  logic                      stat_clr;
  logic [31:0]               stat_lu_stalls;
  logic [31:0]               stat_mc_stalls;
  logic [31:0]               stat_fwd_count;
`endif

  modport master (
    output ifid_rs, ifid_rs_used, ifid_mc, ifid_rd,
    output idex_rs, idex_rd, idex_regwrite, idex_memread,
    output exmem_rd, exmem_regwrite,
    output memwb_rd, memwb_regwrite, ex_flush,
`ifdef FWD_HAZARD_STATS_EN
    output stat_clr,
    input  stat_lu_stalls, stat_mc_stalls, stat_fwd_count,
`endif
    input  forward_sel, stall, mc_busy, mc_rd
  );

  modport slave (
    input  ifid_rs, ifid_rs_used, ifid_mc, ifid_rd,
    input  idex_rs, idex_rd, idex_regwrite, idex_memread,
    input  exmem_rd, exmem_regwrite,
    input  memwb_rd, memwb_regwrite, ex_flush,
`ifdef FWD_HAZARD_STATS_EN
    input  stat_clr,
    output stat_lu_stalls, stat_mc_stalls, stat_fwd_count,
`endif
    output forward_sel, stall, mc_busy, mc_rd
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding, load-use / multi-cycle scoreboard stalls.
// Ports: clk, reset_n, bus (slave). Optional: FWD_HAZARD_STATS_EN.
module fwd_hazard_unit #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int MC_LAT  = 4
) (
  input logic          clk,
  input logic          reset_n,
  fwd_hazard_unit_if.slave bus
);
  localparam int CW = $clog2(MC_LAT + 1);

  typedef enum logic {IDLE, BUSY} st_e;

  st_e               st_q, st_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;

  logic [2*NUM_SRC-1:0] fsel;
  logic [REG_AW-1:0]    rs_ex, rs_id;
  logic                 lu_hit, sb_hit;
  logic                 busy;
  logic                 lu_hz, sb_hz, st_hz;
  logic                 stall, issue;

  always_comb begin
    fsel   = '0;
    rs_ex  = '0;
    rs_id  = '0;
    lu_hit = 1'b0;
    sb_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rs_ex = bus.idex_rs[i*REG_AW +: REG_AW];
      rs_id = bus.ifid_rs[i*REG_AW +: REG_AW];
      if (bus.exmem_regwrite && bus.exmem_rd != '0
          && bus.exmem_rd == rs_ex)
        fsel[2*i +: 2] = 2'b10;
      else if (bus.memwb_regwrite && bus.memwb_rd != '0
               && bus.memwb_rd == rs_ex)
        fsel[2*i +: 2] = 2'b01;
      if (bus.ifid_rs_used[i] && rs_id == bus.idex_rd)
        lu_hit = 1'b1;
      if (bus.ifid_rs_used[i] && rs_id == rd_q)
        sb_hit = 1'b1;
    end
  end

  assign busy  = (st_q == BUSY);
  assign lu_hz = bus.idex_memread && bus.idex_regwrite
              && bus.idex_rd != '0 && lu_hit;
  assign sb_hz = busy && rd_q != '0
              && (sb_hit || bus.ifid_rd == rd_q);
  assign st_hz = bus.ifid_mc && busy;

  // reset_n gates stall so the pipeline is never frozen during reset
  assign stall = reset_n && !bus.ex_flush
              && (lu_hz || sb_hz || st_hz);
  assign issue = bus.ifid_mc && !stall && !bus.ex_flush;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    rd_d  = rd_q;
    unique case (st_q)
      IDLE: begin
        if (issue) begin
          st_d  = BUSY;
          cnt_d = CW'(MC_LAT);
          rd_d  = bus.ifid_rd;
        end
      end
      BUSY: begin
        if (cnt_q == CW'(1)) begin
          st_d  = IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      rd_q  <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
    end
  end

  assign bus.forward_sel = fsel;
  assign bus.stall       = stall;
  assign bus.mc_busy     = busy;
  assign bus.mc_rd       = rd_q;

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] lu_cnt, mc_cnt, fw_cnt;
  logic        lu_inc, mc_inc, fw_inc;

  assign lu_inc = stall && lu_hz;
  assign mc_inc = stall && (sb_hz || st_hz);
  assign fw_inc = |fsel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lu_cnt <= '0;
      mc_cnt <= '0;
      fw_cnt <= '0;
    end else if (bus.stat_clr) begin
      lu_cnt <= '0;
      mc_cnt <= '0;
      fw_cnt <= '0;
    end else begin
      if (lu_inc && !(&lu_cnt)) lu_cnt <= lu_cnt + 32'd1;
      if (mc_inc && !(&mc_cnt)) mc_cnt <= mc_cnt + 32'd1;
      if (fw_inc && !(&fw_cnt)) fw_cnt <= fw_cnt + 32'd1;
    end
  end

  assign bus.stat_lu_stalls = lu_cnt;
  assign bus.stat_mc_stalls = mc_cnt;
  assign bus.stat_fwd_count = fw_cnt;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit (NUM_SRC=2, REG_AW=5, MC_LAT=4).
// Expected values queued at drive time, checked on the falling edge.
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.NUM_SRC(2), .REG_AW(5)) bus ();

  fwd_hazard_unit #(
    .NUM_SRC(2), .REG_AW(5), .MC_LAT(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    string      tag;
    logic [3:0] fsel;
    logic       stall;
    logic       busy;
    logic       rdc;
    logic [4:0] rd;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk({e.tag, "_fsel"}, 32'(bus.forward_sel), 32'(e.fsel));
      chk({e.tag, "_stall"}, 32'(bus.stall), 32'(e.stall));
      chk({e.tag, "_busy"}, 32'(bus.mc_busy), 32'(e.busy));
      if (e.rdc)
        chk({e.tag, "_mcrd"}, 32'(bus.mc_rd), 32'(e.rd));
    end
  end

  task automatic step(input string tag,
                      input logic [3:0] f,
                      input logic s,
                      input logic b,
                      input int rd = -1);
    exp_t e;
    e.tag   = tag;
    e.fsel  = f;
    e.stall = s;
    e.busy  = b;
    e.rdc   = (rd >= 0);
    e.rd    = 5'(rd < 0 ? 0 : rd);
    sbq.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.ifid_rs        = '0;
    bus.ifid_rs_used   = '0;
    bus.ifid_mc        = 1'b0;
    bus.ifid_rd        = '0;
    bus.idex_rs        = '0;
    bus.idex_rd        = '0;
    bus.idex_regwrite  = 1'b0;
    bus.idex_memread   = 1'b0;
    bus.exmem_rd       = '0;
    bus.exmem_regwrite = 1'b0;
    bus.memwb_rd       = '0;
    bus.memwb_regwrite = 1'b0;
    bus.ex_flush       = 1'b0;
  endtask

  task automatic id_rs(input int i, input int r);
    bus.ifid_rs[i*5 +: 5] = 5'(r);
    bus.ifid_rs_used[i]   = 1'b1;
  endtask

  task automatic ex_rs(input int i, input int r);
    bus.idex_rs[i*5 +: 5] = 5'(r);
  endtask

`ifdef FWD_HAZARD_STATS_EN
  task automatic chk_stats(input string tag);
    chk({tag, "_lu"}, bus.stat_lu_stalls, 32'd0);
    chk({tag, "_mc"}, bus.stat_mc_stalls, 32'd0);
    chk({tag, "_fw"}, bus.stat_fwd_count, 32'd0);
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    idle_in();
`ifdef FWD_HAZARD_STATS_EN
    bus.stat_clr = 1'b0;
`endif
    // forwarding live and load-use present while in reset
    ex_rs(0, 7);
    bus.exmem_rd       = 5'd7;
    bus.exmem_regwrite = 1'b1;
    bus.idex_memread   = 1'b1;
    bus.idex_regwrite  = 1'b1;
    bus.idex_rd        = 5'd5;
    id_rs(1, 5);
    step("rst", 4'b0010, 1'b0, 1'b0, 0);
    reset_n = 1'b1;
`ifdef FWD_HAZARD_STATS_EN
    chk_stats("st_rst");
`endif

    idle_in();
    ex_rs(0, 7);
    bus.exmem_rd       = 5'd7;
    bus.exmem_regwrite = 1'b1;
    bus.memwb_rd       = 5'd7;
    bus.memwb_regwrite = 1'b1;
    step("fwd_ex", 4'b0010, 1'b0, 1'b0);
    bus.exmem_regwrite = 1'b0;
    step("fwd_wb", 4'b0001, 1'b0, 1'b0);
    ex_rs(0, 0);
    bus.exmem_rd       = 5'd0;
    bus.memwb_rd       = 5'd0;
    bus.exmem_regwrite = 1'b1;
    step("fwd_x0", 4'b0000, 1'b0, 1'b0);
    idle_in();
    ex_rs(1, 3);
    bus.exmem_rd       = 5'd3;
    bus.memwb_rd       = 5'd3;
    bus.memwb_regwrite = 1'b1;
    step("fwd_op1", 4'b0100, 1'b0, 1'b0);

    idle_in();
    bus.idex_memread  = 1'b1;
    bus.idex_regwrite = 1'b1;
    bus.idex_rd       = 5'd5;
    id_rs(1, 5);
    step("lu", 4'b0000, 1'b1, 1'b0);
    bus.idex_memread  = 1'b0;
    bus.idex_regwrite = 1'b0;
    bus.idex_rd       = 5'd0;
    step("lu_bub", 4'b0000, 1'b0, 1'b0);
    bus.idex_memread  = 1'b1;
    bus.idex_regwrite = 1'b1;
    bus.idex_rd       = 5'd5;
    bus.ifid_rs_used  = 2'b01;
    step("lu_unused", 4'b0000, 1'b0, 1'b0);
    bus.ifid_rs_used  = 2'b10;
    bus.ex_flush      = 1'b1;
    bus.ifid_mc       = 1'b1;
    bus.ifid_rd       = 5'd4;
    step("flush", 4'b0000, 1'b0, 1'b0);
    idle_in();
    step("no_iss", 4'b0000, 1'b0, 1'b0);

    bus.ifid_mc = 1'b1;
    bus.ifid_rd = 5'd9;
    step("mc_iss", 4'b0000, 1'b0, 1'b0);
    idle_in();
    id_rs(0, 9);
    step("raw_c4", 4'b0000, 1'b1, 1'b1, 9);
    idle_in();
    id_rs(0, 2);
    step("indep_c3", 4'b0000, 1'b0, 1'b1);
    idle_in();
    bus.ifid_rd = 5'd9;
    step("waw_c2", 4'b0000, 1'b1, 1'b1);
    idle_in();
    bus.ifid_mc = 1'b1;
    bus.ifid_rd = 5'd10;
    step("struct_c1", 4'b0000, 1'b1, 1'b1, 9);
    step("iss2", 4'b0000, 1'b0, 1'b0);
    idle_in();
    id_rs(0, 10);
    step("raw2_c4", 4'b0000, 1'b1, 1'b1, 10);
    step("raw2_c3", 4'b0000, 1'b1, 1'b1);
    reset_n = 1'b0;
    step("rst_mid", 4'b0000, 1'b0, 1'b0, 0);
`ifdef FWD_HAZARD_STATS_EN
    chk_stats("st_mid");
`endif
    reset_n = 1'b1;
    step("post_rst", 4'b0000, 1'b0, 1'b0);

    idle_in();
    bus.ifid_mc = 1'b1;
    step("iss_x0", 4'b0000, 1'b0, 1'b0);
    idle_in();
    id_rs(0, 0);
    step("x0_c4", 4'b0000, 1'b0, 1'b1, 0);
    step("x0_c3", 4'b0000, 1'b0, 1'b1);
    step("x0_c2", 4'b0000, 1'b0, 1'b1);
    step("x0_c1", 4'b0000, 1'b0, 1'b1);
    step("x0_end", 4'b0000, 1'b0, 1'b0);

`ifdef FWD_HAZARD_STATS_EN
    idle_in();
    ex_rs(0, 7);
    bus.exmem_rd       = 5'd7;
    bus.exmem_regwrite = 1'b1;
    @(posedge clk);
    #1;
    chk("st_fw1", bus.stat_fwd_count, 32'd1);
    idle_in();
    bus.stat_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.stat_clr = 1'b0;
    chk_stats("st_clr");
`endif

    @(negedge clk);
    chk("drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
